// File: rtl/pipe_trap_ctrl.sv
// pipe_trap_ctrl: pipeline hold/flush control plus machine-mode trap sequencer.
// Raises the per-stage hold mask for stalls and mispredicts. Takes MEM exceptions and
// masked interrupts, writes mepc/mcause/mtval, then redirects to mtvec. Also handles mret.
module pipe_trap_ctrl #(
   parameter int STAGES = 5,
   parameter int XLEN   = 32,
   parameter int EXC_W  = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_hold_flag_i,
   input  logic              ex_jump_en_i,
   input  logic              id_ex_jump_en_i,
   input  logic              prd_jump_en_i,
   input  logic              id_hold_flag_i,
   input  logic [EXC_W-1:0]  exception_i,
   input  logic              mem_valid_i,
   input  logic [XLEN-1:0]   mem_pc_i,
   input  logic [XLEN-1:0]   mem_tval_i,
   input  logic              irq_software_i,
   input  logic              irq_timer_i,
   input  logic              irq_external_i,
   input  logic              mstatus_mie_i,
   input  logic              mie_sw_i,
   input  logic              mie_timer_i,
   input  logic              mie_external_i,
   input  logic [XLEN-1:0]   mtvec_i,
   input  logic [XLEN-1:0]   mepc_i,
   output logic              prd_fail_o,
   output logic [STAGES-1:0] hold_en_o,
   output logic              flush_o,
   output logic              trap_jump_en_o,
   output logic [XLEN-1:0]   trap_jump_addr_o,
   output logic              set_cause_o,
   output logic              cause_type_o,
   output logic [3:0]        trap_cause_o,
   output logic              set_mepc_o,
   output logic [XLEN-1:0]   mepc_o,
   output logic              set_mtval_o,
   output logic [XLEN-1:0]   mtval_o,
   output logic              mstatus_mie_clear_o,
   output logic              mstatus_mie_set_o
);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_TRAP_CSR  = 2'd1;
   localparam logic [1:0] S_TRAP_JUMP = 2'd2;
   localparam logic [1:0] S_MRET_JUMP = 2'd3;

   localparam logic [STAGES-1:0] ALL_HOLD = '1;

   logic [1:0]        r_state;
   logic              r_cause_type;
   logic [3:0]        r_cause_code;
   logic [XLEN-1:0]   r_mepc;
   logic [XLEN-1:0]   r_mtval;

   logic              w_prd_fail;
   logic              w_idle;
   logic              w_exc_any;
   logic              w_irq_pend;
   logic              w_event;
   logic              w_tval_keep;
   logic [3:0]        w_exc_code;
   logic [3:0]        w_irq_code;
   logic [STAGES-1:0] w_hold_base;
   logic [XLEN-1:0]   w_vec_off;

   assign w_prd_fail = ex_jump_en_i ^ id_ex_jump_en_i;
   assign w_idle     = (r_state == S_IDLE);
   assign w_exc_any  = |exception_i[6:1];
   assign w_irq_pend = mstatus_mie_i & ((irq_external_i & mie_external_i) |
                                        (irq_software_i & mie_sw_i) |
                                        (irq_timer_i    & mie_timer_i));
   assign w_event    = w_idle & mem_valid_i & (w_exc_any | exception_i[0] | w_irq_pend);
   assign w_vec_off  = {{(XLEN-6){1'b0}}, r_cause_code, 2'b00};

   // Exception cause priority; ecall/ebreak report no mtval
   always_comb begin
      w_exc_code  = 4'd0;
      w_tval_keep = 1'b1;
      if (exception_i[3]) begin
         w_exc_code = 4'd0;
      end else if (exception_i[4]) begin
         w_exc_code = 4'd2;
      end else if (exception_i[2]) begin
         w_exc_code  = 4'd3;
         w_tval_keep = 1'b0;
      end else if (exception_i[1]) begin
         w_exc_code  = 4'd11;
         w_tval_keep = 1'b0;
      end else if (exception_i[5]) begin
         w_exc_code = 4'd6;
      end else if (exception_i[6]) begin
         w_exc_code = 4'd4;
      end
   end

   // Interrupt cause priority: external > software > timer
   always_comb begin
      w_irq_code = 4'd7;
      if (irq_external_i & mie_external_i) begin
         w_irq_code = 4'd11;
      end else if (irq_software_i & mie_sw_i) begin
         w_irq_code = 4'd3;
      end
   end

   // Stall/mispredict hold mask used while no trap activity is in progress
   always_comb begin
      w_hold_base = '0;
      if (ex_hold_flag_i) begin
         w_hold_base = ALL_HOLD >> 1;
      end else if (w_prd_fail) begin
         w_hold_base = ALL_HOLD >> 2;
      end else if (prd_jump_en_i) begin
         w_hold_base = ALL_HOLD >> 3;
      end else if (id_hold_flag_i) begin
         w_hold_base = ALL_HOLD >> 2;
      end
   end

   // Trap sequencer state and cause/pc/tval capture on the detect cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cause_type <= 1'b0;
         r_cause_code <= 4'd0;
         r_mepc       <= '0;
         r_mtval      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_event) begin
                  r_mepc <= mem_pc_i;
                  if (w_exc_any) begin
                     r_state      <= S_TRAP_CSR;
                     r_cause_type <= 1'b0;
                     r_cause_code <= w_exc_code;
                     r_mtval      <= w_tval_keep ? mem_tval_i : '0;
                  end else if (exception_i[0]) begin
                     r_state <= S_MRET_JUMP;
                  end else begin
                     r_state      <= S_TRAP_CSR;
                     r_cause_type <= 1'b1;
                     r_cause_code <= w_irq_code;
                     r_mtval      <= '0;
                  end
               end
            end
            S_TRAP_CSR: r_state <= S_TRAP_JUMP;
            default:    r_state <= S_IDLE;
         endcase
      end
   end

   // Output decode; reset forces every output low even mid-sequence
   always_comb begin
      prd_fail_o          = 1'b0;
      hold_en_o           = '0;
      flush_o             = 1'b0;
      trap_jump_en_o      = 1'b0;
      trap_jump_addr_o    = '0;
      set_cause_o         = 1'b0;
      cause_type_o        = 1'b0;
      trap_cause_o        = 4'd0;
      set_mepc_o          = 1'b0;
      mepc_o              = '0;
      set_mtval_o         = 1'b0;
      mtval_o             = '0;
      mstatus_mie_clear_o = 1'b0;
      mstatus_mie_set_o   = 1'b0;
      if (!rst) begin
         prd_fail_o = w_prd_fail;
         case (r_state)
            S_IDLE: begin
               if (w_event) begin
                  hold_en_o = ALL_HOLD;
                  flush_o   = 1'b1;
               end else begin
                  hold_en_o = w_hold_base;
               end
            end
            S_TRAP_CSR: begin
               hold_en_o           = ALL_HOLD;
               flush_o             = 1'b1;
               set_cause_o         = 1'b1;
               cause_type_o        = r_cause_type;
               trap_cause_o        = r_cause_code;
               set_mepc_o          = 1'b1;
               mepc_o              = r_mepc;
               set_mtval_o         = 1'b1;
               mtval_o             = r_mtval;
               mstatus_mie_clear_o = 1'b1;
            end
            S_TRAP_JUMP: begin
               hold_en_o        = ALL_HOLD;
               flush_o          = 1'b1;
               trap_jump_en_o   = 1'b1;
               trap_jump_addr_o = {mtvec_i[XLEN-1:2], 2'b00} +
                                  (((mtvec_i[1:0] == 2'b01) && r_cause_type) ? w_vec_off : '0);
            end
            default: begin
               hold_en_o         = ALL_HOLD;
               flush_o           = 1'b1;
               trap_jump_en_o    = 1'b1;
               trap_jump_addr_o  = mepc_i;
               mstatus_mie_set_o = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_trap_ctrl.sv
// Bench for pipe_trap_ctrl: cycle model of hold/trap/mret behaviour checked on every
// negedge, plus directed literal checks at the key cycles of each scenario.
module tb_pipe_trap_ctrl;
   localparam int STAGES = 5;
   localparam int XLEN   = 32;
   localparam int EXC_W  = 7;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ex_hold_flag_i = 0, ex_jump_en_i = 0, id_ex_jump_en_i = 0, prd_jump_en_i = 0, id_hold_flag_i = 0;
   logic [EXC_W-1:0] exception_i = '0;
   logic mem_valid_i = 0;
   logic [XLEN-1:0] mem_pc_i = '0, mem_tval_i = '0, mtvec_i = '0, mepc_i = '0;
   logic irq_software_i = 0, irq_timer_i = 0, irq_external_i = 0;
   logic mstatus_mie_i = 0, mie_sw_i = 0, mie_timer_i = 0, mie_external_i = 0;

   logic prd_fail_o, flush_o, trap_jump_en_o, set_cause_o, cause_type_o, set_mepc_o, set_mtval_o;
   logic mstatus_mie_clear_o, mstatus_mie_set_o;
   logic [STAGES-1:0] hold_en_o;
   logic [XLEN-1:0] trap_jump_addr_o, mepc_o, mtval_o;
   logic [3:0] trap_cause_o;

   pipe_trap_ctrl #(.STAGES(STAGES), .XLEN(XLEN), .EXC_W(EXC_W)) dut (
      .clk(clk), .rst(rst),
      .ex_hold_flag_i(ex_hold_flag_i), .ex_jump_en_i(ex_jump_en_i),
      .id_ex_jump_en_i(id_ex_jump_en_i), .prd_jump_en_i(prd_jump_en_i),
      .id_hold_flag_i(id_hold_flag_i), .exception_i(exception_i),
      .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i), .mem_tval_i(mem_tval_i),
      .irq_software_i(irq_software_i), .irq_timer_i(irq_timer_i), .irq_external_i(irq_external_i),
      .mstatus_mie_i(mstatus_mie_i), .mie_sw_i(mie_sw_i), .mie_timer_i(mie_timer_i),
      .mie_external_i(mie_external_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
      .prd_fail_o(prd_fail_o), .hold_en_o(hold_en_o), .flush_o(flush_o),
      .trap_jump_en_o(trap_jump_en_o), .trap_jump_addr_o(trap_jump_addr_o),
      .set_cause_o(set_cause_o), .cause_type_o(cause_type_o), .trap_cause_o(trap_cause_o),
      .set_mepc_o(set_mepc_o), .mepc_o(mepc_o), .set_mtval_o(set_mtval_o), .mtval_o(mtval_o),
      .mstatus_mie_clear_o(mstatus_mie_clear_o), .mstatus_mie_set_o(mstatus_mie_set_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Exception priority table: exception_i bit index and its cause code, highest first
   int ebit  [6] = '{3, 4, 2, 1, 5, 6};
   int ecode [6] = '{0, 2, 3, 11, 6, 4};

   // Model: phase counts cycles since the event was accepted (0 = waiting for events)
   int         m_phase = 0, n_phase = 0;
   bit         m_mret = 0, n_mret = 0, m_irq = 0, n_irq = 0;
   int         m_code = 0, n_code = 0;
   logic [31:0] m_pc = 0, n_pc = 0, m_tval = 0, n_tval = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = 0; m_mret = 0; m_irq = 0; m_code = 0; m_pc = 0; m_tval = 0;
      end else begin
         m_phase = n_phase; m_mret = n_mret; m_irq = n_irq;
         m_code = n_code; m_pc = n_pc; m_tval = n_tval;
      end
   end

   always @(negedge clk) begin : model_cmp
      int e_hold, e_code, k, vk;
      bit e_prd, e_flush, e_jmp, e_setc, e_ctype, e_clr, e_set, found, keep, irq_any;
      logic [31:0] e_addr, e_mepc, e_mtval;
      e_hold = 0; e_code = 0; e_prd = 0; e_flush = 0; e_jmp = 0; e_setc = 0; e_ctype = 0;
      e_clr = 0; e_set = 0; e_addr = 0; e_mepc = 0; e_mtval = 0;
      n_phase = m_phase; n_mret = m_mret; n_irq = m_irq; n_code = m_code; n_pc = m_pc; n_tval = m_tval;
      if (rst) begin
         n_phase = 0;
      end else begin
         e_prd = (ex_jump_en_i != id_ex_jump_en_i);
         if (m_phase == 0) begin
            found = 0; keep = 0;
            for (int i = 0; i < 6; i++) begin
               if (!found && exception_i[ebit[i]]) begin
                  found = 1;
                  e_code = ecode[i];
                  keep = !(ecode[i] == 3 || ecode[i] == 11);
               end
            end
            irq_any = mstatus_mie_i && ((irq_external_i && mie_external_i) ||
                      (irq_software_i && mie_sw_i) || (irq_timer_i && mie_timer_i));
            if (mem_valid_i && (found || exception_i[0] || irq_any)) begin
               e_hold = (1 << STAGES) - 1;
               e_flush = 1;
               n_pc = mem_pc_i;
               n_phase = 1;
               if (found) begin
                  n_mret = 0; n_irq = 0; n_code = e_code; n_tval = keep ? mem_tval_i : 0;
               end else if (exception_i[0]) begin
                  n_mret = 1;
               end else begin
                  n_mret = 0; n_irq = 1; n_tval = 0;
                  if (irq_external_i && mie_external_i) n_code = 11;
                  else if (irq_software_i && mie_sw_i) n_code = 3;
                  else n_code = 7;
               end
            end else begin
               k = ex_hold_flag_i ? STAGES - 1 : e_prd ? STAGES - 2 :
                   prd_jump_en_i ? STAGES - 3 : id_hold_flag_i ? STAGES - 2 : 0;
               e_hold = (1 << k) - 1;
            end
         end else begin
            e_hold = (1 << STAGES) - 1;
            e_flush = 1;
            if (m_phase == 1 && m_mret) begin
               e_jmp = 1; e_addr = mepc_i; e_set = 1; n_phase = 0;
            end else if (m_phase == 1) begin
               e_setc = 1; e_ctype = m_irq; e_code = m_code; e_mepc = m_pc; e_mtval = m_tval;
               e_clr = 1; n_phase = 2;
            end else begin
               vk = (mtvec_i[1:0] == 2'b01 && m_irq) ? 4 * m_code : 0;
               e_jmp = 1; e_addr = (mtvec_i & ~32'h3) + vk; n_phase = 0;
            end
         end
      end
      chk("m_prd_fail", prd_fail_o, e_prd);
      chk("m_hold", hold_en_o, e_hold);
      chk("m_flush", flush_o, e_flush);
      chk("m_jump_en", trap_jump_en_o, e_jmp);
      chk("m_set_cause", set_cause_o, e_setc);
      chk("m_set_mepc", set_mepc_o, e_setc);
      chk("m_set_mtval", set_mtval_o, e_setc);
      chk("m_mie_clear", mstatus_mie_clear_o, e_clr);
      chk("m_mie_set", mstatus_mie_set_o, e_set);
      if (e_jmp) chk("m_jump_addr", trap_jump_addr_o, e_addr);
      if (e_setc) begin
         chk("m_cause_type", cause_type_o, e_ctype);
         chk("m_cause", trap_cause_o, e_code);
         chk("m_mepc", mepc_o, e_mepc);
         chk("m_mtval", mtval_o, e_mtval);
      end
   end

   task automatic cyc(); @(posedge clk); #1; endtask
   task automatic smp(); @(negedge clk); endtask
   task automatic clr_ev();
      exception_i = '0; mem_valid_i = 0;
      ex_hold_flag_i = 0; ex_jump_en_i = 0; id_ex_jump_en_i = 0; prd_jump_en_i = 0; id_hold_flag_i = 0;
   endtask

   initial begin
      repeat (2) smp();
      chk("rst_hold", hold_en_o, 0);
      chk("rst_flush", flush_o, 0);
      @(posedge clk); #1 rst = 0;
      mtvec_i = 32'h100;

      // hold mask priorities
      cyc(); ex_hold_flag_i = 1; ex_jump_en_i = 1; smp();
      chk("hold_exhold_prdfail", hold_en_o, 5'b01111);
      chk("prd_fail_set", prd_fail_o, 1);
      cyc(); clr_ev(); prd_jump_en_i = 1; smp();
      chk("hold_prd_jump", hold_en_o, 5'b00011);
      cyc(); clr_ev(); id_ex_jump_en_i = 1; smp();
      chk("hold_prd_fail", hold_en_o, 5'b00111);
      cyc(); clr_ev(); id_hold_flag_i = 1; smp();
      chk("hold_id", hold_en_o, 5'b00111);
      cyc(); clr_ev(); smp();
      chk("hold_none", hold_en_o, 0);

      // illegal instruction trap
      cyc(); exception_i = 7'b0010000; mem_valid_i = 1; mem_pc_i = 32'h80; mem_tval_i = 32'h73; smp();
      chk("ill_detect_hold", hold_en_o, 5'b11111);
      chk("ill_detect_flush", flush_o, 1);
      cyc(); clr_ev(); smp();
      chk("ill_cause", trap_cause_o, 2);
      chk("ill_mepc", mepc_o, 32'h80);
      chk("ill_mtval", mtval_o, 32'h73);
      chk("ill_mie_clear", mstatus_mie_clear_o, 1);
      cyc(); smp();
      chk("ill_jump_en", trap_jump_en_o, 1);
      chk("ill_jump_addr", trap_jump_addr_o, 32'h100);
      cyc(); smp();
      chk("ill_done", trap_jump_en_o, 0);

      // no valid instruction in MEM: nothing is taken
      cyc(); exception_i = 7'b0010000; smp();
      chk("novalid_flush", flush_o, 0);
      cyc(); clr_ev(); smp();

      // vectored timer interrupt, waits for mem_valid
      cyc(); mstatus_mie_i = 1; mie_timer_i = 1; irq_timer_i = 1; mtvec_i = 32'h101; smp();
      chk("irq_wait", flush_o, 0);
      cyc(); mem_valid_i = 1; mem_pc_i = 32'h200; smp();
      chk("irq_detect", flush_o, 1);
      cyc(); irq_timer_i = 0; mem_valid_i = 0; smp();
      chk("tmr_type", cause_type_o, 1);
      chk("tmr_code", trap_cause_o, 7);
      chk("tmr_mtval", mtval_o, 0);
      cyc(); smp();
      chk("tmr_addr", trap_jump_addr_o, 32'h11C);

      // external beats timer; still pending irq re-detected; masked by mstatus
      cyc(); irq_external_i = 1; mie_external_i = 1; irq_timer_i = 1; mem_valid_i = 1; smp();
      cyc(); smp();
      chk("ext_code", trap_cause_o, 11);
      cyc(); smp();
      chk("ext_addr", trap_jump_addr_o, 32'h12C);
      cyc(); smp();
      chk("irq_recheck", flush_o, 1);
      cyc(); smp(); cyc(); smp();
      cyc(); mstatus_mie_i = 0; smp();
      chk("irq_masked", flush_o, 0);
      cyc(); irq_external_i = 0; irq_timer_i = 0; clr_ev(); mtvec_i = 32'h100; smp();

      // mret
      cyc(); exception_i = 7'b0000001; mem_valid_i = 1; mepc_i = 32'h84; smp();
      chk("mret_detect", flush_o, 1);
      cyc(); clr_ev(); smp();
      chk("mret_jump", trap_jump_en_o, 1);
      chk("mret_addr", trap_jump_addr_o, 32'h84);
      chk("mret_mie_set", mstatus_mie_set_o, 1);
      chk("mret_no_cause", set_cause_o, 0);
      cyc(); smp();

      // reset during TRAP_CSR aborts
      cyc(); exception_i = 7'b0000010; mem_valid_i = 1; mem_pc_i = 32'h300; smp();
      cyc(); clr_ev(); #1;
      chk("abort_pre", set_cause_o, 1);
      rst = 1; #1;
      chk("abort_cause", set_cause_o, 0);
      chk("abort_hold", hold_en_o, 0);
      chk("abort_flush", flush_o, 0);
      smp(); cyc(); rst = 0; smp();
      chk("abort_nojump", trap_jump_en_o, 0);
      cyc(); smp();

      // ecall + mret: exception wins, cause 11, mtval 0
      cyc(); exception_i = 7'b0000011; mem_valid_i = 1; mem_pc_i = 32'h400; mem_tval_i = 32'hDEAD; smp();
      cyc(); clr_ev(); smp();
      chk("ecall_cause", trap_cause_o, 11);
      chk("ecall_mtval", mtval_o, 0);
      chk("ecall_no_mie_set", mstatus_mie_set_o, 0);
      cyc(); smp();
      chk("ecall_addr", trap_jump_addr_o, 32'h100);

      // ebreak; events while busy are not queued
      cyc(); exception_i = 7'b0000100; mem_valid_i = 1; mem_pc_i = 32'h500; smp();
      cyc(); exception_i = 7'b0010000; smp();
      chk("ebreak_code", trap_cause_o, 3);
      cyc(); smp();
      cyc(); clr_ev(); smp();
      chk("no_queue", flush_o, 0);

      // mis_store outranks mis_load, keeps tval
      cyc(); exception_i = 7'b1100000; mem_valid_i = 1; mem_pc_i = 32'h600; mem_tval_i = 32'h1234; smp();
      cyc(); clr_ev(); smp();
      chk("store_code", trap_cause_o, 6);
      chk("store_mtval", mtval_o, 32'h1234);
      cyc(); smp(); cyc(); smp();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
